// File: rtl/bj_predict_unit_if.sv
// Fetch-lookup and execute-resolve bundle for bj_predict_unit.
// The master side drives fetch/execute requests; the slave is the unit itself.
interface bj_predict_unit_if #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 F_VALID;
    logic [XLEN-1:0]      F_PC;
    logic                 PRED_TAKEN;
    logic [XLEN-1:0]      PRED_TARGET;
    logic                 E_VALID;
    logic [1:0]           BJ_CTRL;
    logic [2:0]           FUNC3;
    logic [XLEN-1:0]      E_PC;
    logic [XLEN-1:0]      E_IMM;
    logic [XLEN-1:0]      E_RS1;
    logic                 ZERO;
    logic                 SIGN_BIT;
    logic                 SLTU_BIT;
    logic                 E_PRED_TAKEN;
    logic [XLEN-1:0]      E_PRED_TARGET;
    logic                 FLUSH;
    logic [XLEN-1:0]      REDIRECT_PC;
    logic                 BRANCH_SEL;
    logic [XLEN-1:0]      B_PC;
    logic [CNT_WIDTH-1:0] BRANCH_COUNT;
    logic [CNT_WIDTH-1:0] MISPREDICT_COUNT;

    modport master (
        output F_VALID, F_PC, E_VALID, BJ_CTRL, FUNC3, E_PC, E_IMM, E_RS1,
               ZERO, SIGN_BIT, SLTU_BIT, E_PRED_TAKEN, E_PRED_TARGET,
        input  PRED_TAKEN, PRED_TARGET, FLUSH, REDIRECT_PC, BRANCH_SEL, B_PC,
               BRANCH_COUNT, MISPREDICT_COUNT
    );

    modport slave (
        input  F_VALID, F_PC, E_VALID, BJ_CTRL, FUNC3, E_PC, E_IMM, E_RS1,
               ZERO, SIGN_BIT, SLTU_BIT, E_PRED_TAKEN, E_PRED_TARGET,
        output PRED_TAKEN, PRED_TARGET, FLUSH, REDIRECT_PC, BRANCH_SEL, B_PC,
               BRANCH_COUNT, MISPREDICT_COUNT
    );
endinterface

// File: rtl/bj_predict_unit.sv
// Branch/jump resolution with a direct-mapped BHT (2-bit counters) and tagged BTB.
// Fetch lookup is combinational; execute resolve/flush is registered one cycle later.
module bj_predict_unit #(
    parameter int XLEN      = 32,
    parameter int IDX_BITS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input logic              CLK,
    input logic              RESET,
    bj_predict_unit_if.slave bus
);
    localparam int ENTRIES = 2**IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [ENTRIES-1:0][1:0]       bht_q, bht_d;
    logic [ENTRIES-1:0]            btb_valid_q, btb_valid_d;
    logic [ENTRIES-1:0]            btb_jump_q, btb_jump_d;
    logic [ENTRIES-1:0][TAG_W-1:0] btb_tag_q, btb_tag_d;
    logic [ENTRIES-1:0][XLEN-1:0]  btb_target_q, btb_target_d;

    logic                 flush_q, flush_d;
    logic                 branch_sel_q, branch_sel_d;
    logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0]      b_pc_q, b_pc_d;
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] f_idx, e_idx;
    logic [TAG_W-1:0]    f_tag, e_tag;
    logic                f_hit, f_taken;

    logic            active, is_branch, cond_ok, cond_taken, taken, mispredict;
    logic [XLEN-1:0] jalr_sum, target;

    // Lookup reads only _q state, so a same-cycle update to the same index is not visible yet.
    assign f_idx   = bus.F_PC[IDX_BITS+1:2];
    assign f_tag   = bus.F_PC[XLEN-1:IDX_BITS+2];
    assign f_hit   = bus.F_VALID & btb_valid_q[f_idx] & (btb_tag_q[f_idx] == f_tag);
    assign f_taken = f_hit & (btb_jump_q[f_idx] | bht_q[f_idx][1]);

    assign bus.PRED_TAKEN  = f_taken;
    assign bus.PRED_TARGET = f_taken ? btb_target_q[f_idx] : bus.F_PC + XLEN'(4);

    always_comb begin
        e_idx      = bus.E_PC[IDX_BITS+1:2];
        e_tag      = bus.E_PC[XLEN-1:IDX_BITS+2];
        // Whatever arrives while a flush is out is wrong-path work.
        active     = bus.E_VALID & (bus.BJ_CTRL != 2'b00) & ~flush_q;
        is_branch  = (bus.BJ_CTRL == 2'b01);
        cond_ok    = 1'b1;
        cond_taken = 1'b0;
        case (bus.FUNC3)
            3'b000:  cond_taken = bus.ZERO;
            3'b001:  cond_taken = ~bus.ZERO;
            3'b100:  cond_taken = bus.SIGN_BIT;
            3'b101:  cond_taken = ~bus.SIGN_BIT;
            3'b110:  cond_taken = bus.SLTU_BIT;
            3'b111:  cond_taken = ~bus.SLTU_BIT;
            default: cond_ok    = 1'b0;
        endcase
        jalr_sum   = bus.E_RS1 + bus.E_IMM;
        target     = (bus.BJ_CTRL == 2'b11) ? (jalr_sum & ALIGN_MASK) : bus.E_PC + bus.E_IMM;
        taken      = is_branch ? cond_taken : 1'b1;
        mispredict = (taken != bus.E_PRED_TAKEN) | (taken & (target != bus.E_PRED_TARGET));

        bht_d              = bht_q;
        btb_valid_d        = btb_valid_q;
        btb_jump_d         = btb_jump_q;
        btb_tag_d          = btb_tag_q;
        btb_target_d       = btb_target_q;
        flush_d            = 1'b0;
        branch_sel_d       = 1'b0;
        redirect_pc_d      = redirect_pc_q;
        b_pc_d             = b_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (active) begin
            flush_d       = mispredict;
            branch_sel_d  = taken;
            b_pc_d        = target;
            redirect_pc_d = taken ? target : bus.E_PC + XLEN'(4);
            if (branch_count_q != '1)
                branch_count_d = branch_count_q + CNT_WIDTH'(1);
            if (mispredict && (mispredict_count_q != '1))
                mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
            if (is_branch && cond_ok) begin
                if (taken && (bht_q[e_idx] != 2'b11))
                    bht_d[e_idx] = bht_q[e_idx] + 2'b01;
                else if (!taken && (bht_q[e_idx] != 2'b00))
                    bht_d[e_idx] = bht_q[e_idx] - 2'b01;
            end
            if (taken) begin
                btb_valid_d[e_idx]  = 1'b1;
                btb_jump_d[e_idx]   = ~is_branch;
                btb_tag_d[e_idx]    = e_tag;
                btb_target_d[e_idx] = target;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bht_q              <= {ENTRIES{2'b01}};
            btb_valid_q        <= '0;
            btb_jump_q         <= '0;
            btb_tag_q          <= '0;
            btb_target_q       <= '0;
            flush_q            <= 1'b0;
            branch_sel_q       <= 1'b0;
            redirect_pc_q      <= '0;
            b_pc_q             <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            btb_valid_q        <= btb_valid_d;
            btb_jump_q         <= btb_jump_d;
            btb_tag_q          <= btb_tag_d;
            btb_target_q       <= btb_target_d;
            flush_q            <= flush_d;
            branch_sel_q       <= branch_sel_d;
            redirect_pc_q      <= redirect_pc_d;
            b_pc_q             <= b_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.FLUSH            = flush_q;
    assign bus.BRANCH_SEL       = branch_sel_q;
    assign bus.REDIRECT_PC      = redirect_pc_q;
    assign bus.B_PC             = b_pc_q;
    assign bus.BRANCH_COUNT     = branch_count_q;
    assign bus.MISPREDICT_COUNT = mispredict_count_q;
endmodule

// File: doc/bj_predict_unit.md
Name: bj_predict_unit

Overview:
Parametrised branch/jump resolution unit with a direct-mapped prediction table.
- Fetch side: a same-cycle lookup predicts taken/target from a branch history table (BHT) of 2-bit saturating counters and a tagged branch target buffer (BTB).
- Execute side: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR from ALU flags, compares the outcome with the prediction carried down the pipeline, and issues a registered flush/redirect.
- Updates the tables and keeps saturating performance counters.

Parameters:
XLEN, 32, datapath/PC width.
IDX_BITS, 4, table index width; the BHT and BTB each have 2**IDX_BITS entries.
CNT_WIDTH, 16, width of the performance counters.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
F_VALID  input  1  fetch lookup valid.
F_PC  input  XLEN  fetch PC.
PRED_TAKEN  output  1  combinational prediction for F_PC.
PRED_TARGET  output  XLEN  predicted next PC: BTB target if PRED_TAKEN, else F_PC+4.
E_VALID  input  1  execute-stage instruction valid.
BJ_CTRL  input  2  00 none, 01 conditional branch, 10 JAL, 11 JALR.
FUNC3  input  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
E_PC  input  XLEN  PC of the execute instruction.
E_IMM  input  XLEN  sign-extended immediate.
E_RS1  input  XLEN  JALR base register.
ZERO  input  1  rs1==rs2.
SIGN_BIT  input  1  rs1<rs2 signed.
SLTU_BIT  input  1  rs1<rs2 unsigned.
E_PRED_TAKEN  input  1  prediction made at fetch, carried down the pipeline.
E_PRED_TARGET  input  XLEN  predicted target, carried down the pipeline.
FLUSH  output  1  registered mispredict flush.
REDIRECT_PC  output  XLEN  registered correct next PC.
BRANCH_SEL  output  1  registered actual-taken.
B_PC  output  XLEN  registered computed target.
BRANCH_COUNT  output  CNT_WIDTH  resolved control transfers, saturating.
MISPREDICT_COUNT  output  CNT_WIDTH  flushes issued, saturating.

Behaviour:
- Reset (async, immediate):
  - All registered outputs are 0, and both counters are 0.
  - Every BHT entry is 01 (weakly not-taken); every BTB valid bit is cleared.
  - A FLUSH pending when reset asserts is dropped.
- Index and tag:
  - idx = PC[IDX_BITS+1:2]; tag = PC[XLEN-1:IDX_BITS+2].
  - Each BTB entry holds valid, tag, target and is_jump.
- Lookup (combinational):
  - hit = F_VALID & valid[idx] & tag match.
  - PRED_TAKEN = hit & (is_jump | BHT[idx][1]).
- Resolve ("active" = E_VALID & BJ_CTRL!=00 & !FLUSH):
  - Branch: target = E_PC+E_IMM. Taken conditions: BEQ ZERO; BNE !ZERO; BLT SIGN_BIT; BGE !SIGN_BIT; BLTU SLTU_BIT; BGEU !SLTU_BIT.
  - FUNC3 010/011 is treated as not-taken and does no BHT/BTB update.
  - JAL: target = E_PC+E_IMM, always taken.
  - JALR: target = (E_RS1+E_IMM) with bit 0 cleared, always taken.
  - All additions are modulo 2**XLEN.
- Mispredict = taken!=E_PRED_TAKEN, or (taken & target!=E_PRED_TARGET).
- Registered outputs (one cycle after an active resolve):
  - BRANCH_SEL=taken; B_PC=target.
  - FLUSH=mispredict; REDIRECT_PC = taken ? target : E_PC+4.
  - When not active: FLUSH=0, BRANCH_SEL=0; B_PC and REDIRECT_PC hold.
- Wrong-path suppression: in any cycle with FLUSH=1, the E_* inputs are wrong-path and ignored. There is no output, no table update and no count, so FLUSH lasts exactly one cycle.
- Table update (same edge as the resolve):
  - Valid branch: BHT[idx] increments if taken, decrements if not, saturating at 00 and 11.
  - Taken: BTB[idx] is written with valid=1, tag, target, and is_jump = (BJ_CTRL!=01). This overwrites any aliasing entry.
  - Not-taken: BTB is unchanged.
  - Jumps do not touch the BHT.
- Simultaneous lookup and update of the same idx: the lookup sees the pre-update value (read-before-write).
- Counters:
  - BRANCH_COUNT increments on every active resolve; MISPREDICT_COUNT increments on every mispredict.
  - Both hold at all-ones.
- Latency: prediction 0 cycles; resolution/flush 1 cycle.

Test Plan:
All scenarios use IDX_BITS=4.
1. Reset, then F_VALID=1, F_PC=0x40 -> PRED_TAKEN=0, PRED_TARGET=0x44; FLUSH=0; both counts 0.
2. Active BEQ, E_PC=0x40, E_IMM=0x20, ZERO=1, E_PRED_TAKEN=0 -> next cycle:
   - FLUSH=1, REDIRECT_PC=0x60, BRANCH_SEL=1, B_PC=0x60, BRANCH_COUNT=1, MISPREDICT_COUNT=1.
   - Lookup of 0x40 then gives PRED_TAKEN=1, PRED_TARGET=0x60.
3. Same BEQ with ZERO=0, E_PRED_TAKEN=1, E_PRED_TARGET=0x60 -> FLUSH=1, REDIRECT_PC=0x44, BHT back to 01, lookup of 0x40 gives PRED_TAKEN=0.
4. JALR with E_RS1=0x1003, E_IMM=4, E_PRED_TAKEN=1, E_PRED_TARGET=0x1006 -> B_PC=0x1006, BRANCH_SEL=1, FLUSH=0, MISPREDICT_COUNT unchanged.
5. A taken BNE presented during the FLUSH=1 cycle -> ignored: FLUSH=0 next cycle, counts and tables unchanged.
6. Aliasing: after a taken branch at 0x40, lookup F_PC=0x440 (same idx 0, different tag) -> PRED_TAKEN=0, PRED_TARGET=0x444. Also assert RESET mid-FLUSH -> FLUSH=0 immediately.
